game_sequencer: RTL
===================

// Module: game_sequencer
// PURPOSE
//  Top-level brick-breaker game controller; sequences the ball datapath across serve, play, pause, loss and win.
//  Drives game_run and a ball reset into the ball block.
//  Consumes the ball's out-of-bounds flag and the brick field's all-clear flag.
//  Tracks lives and level; sits between the button inputs, the ball, the brick field and the VGA overlay.
// PARAMETERS
//  LIVES_INIT   3   lives loaded on a new game; legal range 1..7
//  SERVE_FRAMES 60  frame ticks spent in SERVE before the ball launches; legal range 1..255
//  MAX_LEVEL    15  level counter saturates here; legal range 1..15
// PORTS
//  clk                 in   1  system clock
//  rst                 in   1  synchronous, active-high reset
//  start_btn           in   1  raw start button, asynchronous
//  pause_btn           in   1  raw pause button, asynchronous
//  frame_tick          in   1  one-clk pulse per video frame
//  ball_out_of_bounds  in   1  from ball; sticky until ball reset
//  bricks_all_clear    in   1  from brick field; level cleared
//  game_run            out  1  ball-advance enable
//  ball_rst            out  1  ball reset; holds ball at centre
//  lives               out  3  remaining lives
//  level               out  4  current level, starts at 1
//  state               out  3  FSM code, for the overlay
//  game_over           out  1  high while in OVER
// BEHAVIOUR
//  - One clock domain. Reset is synchronous and active-high.
//  - Reset values:
//    - state=IDLE, lives=LIVES_INIT, level=1, serve_cnt=0
//    - game_run=0, ball_rst=1, game_over=0
//    - edge-detect flops=0
//  - Buttons: each goes through a 2-FF synchroniser, then rising-edge detect, giving a one-clk start_p / pause_p.
//    Button-to-FSM latency is 3 clk.
//  - All outputs are registered from the state register:
//    - game_run=1 only in PLAY
//    - ball_rst=0 only in PLAY and PAUSE
//    - game_over=1 only in OVER
//  - States and codes: IDLE=0 SERVE=1 PLAY=2 PAUSE=3 LOST=4 WIN=5 OVER=6. Codes 7 and any other illegal code go to IDLE.
//  - Transitions:
//    - IDLE: start_p -> SERVE; lives<=LIVES_INIT, level<=1, serve_cnt<=0.
//    - SERVE: each frame_tick increments serve_cnt.
//      On the frame_tick where serve_cnt==SERVE_FRAMES-1 -> PLAY, serve_cnt<=0.
//    - PLAY, in priority order:
//      1. bricks_all_clear -> WIN
//      2. ball_out_of_bounds -> LOST; lives<=lives-1 on the same edge
//      3. pause_p -> PAUSE
//      Rule 1 over rule 2 means a simultaneous clear and loss counts as a win and costs no life.
//    - LOST: exactly 1 clk. lives==0 -> OVER, else -> SERVE with serve_cnt<=0.
//    - WIN: start_p -> SERVE; level<=min(level+1, MAX_LEVEL); lives unchanged.
//    - OVER: start_p -> SERVE; lives<=LIVES_INIT, level<=1.
//    - PAUSE: pause_p -> PLAY. start_p is ignored. serve_cnt and lives hold.
//  - Decrementing lives when lives==0 is unreachable by construction.
//    The implementation guards it anyway: lives saturates at 0.
//  - frame_tick is ignored outside SERVE.
//  - start_p is ignored in SERVE, PLAY and LOST.
//  - rst asserted in any state overrides everything and gives reset values on the next clk.
// CONFIGURATION
//  - GAME_PAUSE_EN defined: the PAUSE state and the pause_btn path are built as described above.
//  - GAME_PAUSE_EN undefined: pause_btn is unused, with no synchroniser instantiated. PAUSE is unreachable.
//    PLAY leaves only on all-clear or out-of-bounds. Code 3 is treated as illegal and goes to IDLE.
// STRUCTURE
//  - Package game_pkg holds:
//    - state enum/localparams ST_IDLE..ST_OVER and the widths LIVES_W=3, LEVEL_W=4, STATE_W=3
//    - these are shared with the ball, brick and overlay blocks
//  - Sub-module btn_edge_detect (2-FF sync + rising edge, ports clk/rst/btn_in/pulse_out):
//    - instantiated for start
//    - instantiated for pause only under GAME_PAUSE_EN
//  - serve_cnt is 8 bits wide, local to this module.
// TESTING
//  - Reset, then start_btn high for 5 clk:
//    - state goes IDLE->SERVE 3 clk after the rising edge
//    - ball_rst stays 1
//    - after 60 frame_ticks -> PLAY with game_run=1, ball_rst=0
//  - In PLAY, pulse ball_out_of_bounds 3 times (full serve each time):
//    - lives 3->2->1->0
//    - the third loss goes LOST->OVER with game_over=1 and game_run=0
//    - then start -> SERVE with lives=3, level=1
//  - In PLAY, assert bricks_all_clear and ball_out_of_bounds in the same clk:
//    - -> WIN and lives unchanged
//    - start -> SERVE with level=2
//    - repeat to level 15, then one more win: level stays 15
//  - GAME_PAUSE_EN defined:
//    - pause_btn edge in PLAY -> PAUSE with game_run=0, ball_rst=0
//    - start_btn is ignored
//    - a second pause edge -> PLAY
//    - GAME_PAUSE_EN undefined: pause edges leave PLAY unchanged
//  - Assert rst during SERVE at serve_cnt=30: next clk gives IDLE, lives=3, level=1, serve_cnt=0, ball_rst=1.
//  - frame_ticks during IDLE, PLAY or WIN do not advance serve_cnt: the first SERVE still lasts exactly 60 ticks.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game types: FSM state codes and field widths used by the sequencer,
// ball, brick and overlay blocks.
package game_pkg;

  localparam int LIVES_W = 3;
  localparam int LEVEL_W = 4;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_SERVE = 3'd1;
  localparam logic [STATE_W-1:0] ST_PLAY  = 3'd2;
  localparam logic [STATE_W-1:0] ST_PAUSE = 3'd3;
  localparam logic [STATE_W-1:0] ST_LOST  = 3'd4;
  localparam logic [STATE_W-1:0] ST_WIN   = 3'd5;
  localparam logic [STATE_W-1:0] ST_OVER  = 3'd6;

  typedef struct packed {
    logic gameRun;
    logic ballRst;
    logic gameOver;
  } game_outs_t;

  // Output decode is a pure function of the state code, so the output flops
  // can be loaded from the next-state value and always match the state register.
  function automatic game_outs_t decodeOutputs(input logic [STATE_W-1:0] st);
    game_outs_t o;
    o.gameRun  = (st == ST_PLAY);
    o.ballRst  = !((st == ST_PLAY) || (st == ST_PAUSE));
    o.gameOver = (st == ST_OVER);
    return o;
  endfunction

  function automatic logic [LEVEL_W-1:0] satIncLevel(input logic [LEVEL_W-1:0] lvl,
                                                     input logic [LEVEL_W-1:0] maxLvl);
    if (lvl >= maxLvl) begin
      return maxLvl;
    end
    return lvl + 1'b1;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Two-flop synchroniser for a raw asynchronous button followed by a
// rising-edge detector producing a one-clock pulse.
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse_out
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Pulse comes straight off the flops so the FSM sees it on the third edge.
  assign pulse_out = sync2_q & ~prev_q;

endmodule

// File: rtl/game_sequencer.sv
// Brick-breaker game controller: serve / play / pause / lost / win / over.
// Define GAME_PAUSE_EN to build the PAUSE state and the pause button path.
module game_sequencer
  import game_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int MAX_LEVEL    = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               frame_tick,
  input  logic               ball_out_of_bounds,
  input  logic               bricks_all_clear,
  output logic               game_run,
  output logic               ball_rst,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] level,
  output logic [STATE_W-1:0] state,
  output logic               game_over
);

  localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);
  localparam logic [7:0]         SERVE_LAST = 8'(SERVE_FRAMES - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [7:0]         serveCnt_q, serveCnt_d;
  logic               gameRun_q, ballRst_q, gameOver_q;
  game_outs_t         outs_d;
  logic               startP;

  btn_edge_detect uStartEdge (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (start_btn),
    .pulse_out(startP)
  );

`ifdef GAME_PAUSE_EN
  logic pauseP;

  btn_edge_detect uPauseEdge (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (pause_btn),
    .pulse_out(pauseP)
  );
`else
  logic unusedPauseBtn;
  assign unusedPauseBtn = pause_btn;
`endif

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    level_d    = level_q;
    serveCnt_d = serveCnt_q;

    case (state_q)
      ST_IDLE: begin
        if (startP) begin
          state_d    = ST_SERVE;
          lives_d    = LIVES_LOAD;
          level_d    = LEVEL_ONE;
          serveCnt_d = 8'd0;
        end
      end

      ST_SERVE: begin
        if (frame_tick) begin
          if (serveCnt_q == SERVE_LAST) begin
            state_d    = ST_PLAY;
            serveCnt_d = 8'd0;
          end else begin
            serveCnt_d = serveCnt_q + 8'd1;
          end
        end
      end

      // A simultaneous clear and loss is a win and costs no life.
      ST_PLAY: begin
        if (bricks_all_clear) begin
          state_d = ST_WIN;
        end else if (ball_out_of_bounds) begin
          state_d = ST_LOST;
          lives_d = (lives_q == '0) ? '0 : lives_q - 1'b1;
        end
`ifdef GAME_PAUSE_EN
        else if (pauseP) begin
          state_d = ST_PAUSE;
        end
`endif
      end

`ifdef GAME_PAUSE_EN
      ST_PAUSE: begin
        if (pauseP) begin
          state_d = ST_PLAY;
        end
      end
`endif

      ST_LOST: begin
        if (lives_q == '0) begin
          state_d = ST_OVER;
        end else begin
          state_d    = ST_SERVE;
          serveCnt_d = 8'd0;
        end
      end

      ST_WIN: begin
        if (startP) begin
          state_d    = ST_SERVE;
          level_d    = satIncLevel(level_q, LEVEL_MAX);
          serveCnt_d = 8'd0;
        end
      end

      ST_OVER: begin
        if (startP) begin
          state_d    = ST_SERVE;
          lives_d    = LIVES_LOAD;
          level_d    = LEVEL_ONE;
          serveCnt_d = 8'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign outs_d = decodeOutputs(state_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lives_q    <= LIVES_LOAD;
      level_q    <= LEVEL_ONE;
      serveCnt_q <= 8'd0;
      gameRun_q  <= 1'b0;
      ballRst_q  <= 1'b1;
      gameOver_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      level_q    <= level_d;
      serveCnt_q <= serveCnt_d;
      gameRun_q  <= outs_d.gameRun;
      ballRst_q  <= outs_d.ballRst;
      gameOver_q <= outs_d.gameOver;
    end
  end

  assign game_run  = gameRun_q;
  assign ball_rst  = ballRst_q;
  assign game_over = gameOver_q;
  assign lives     = lives_q;
  assign level     = level_q;
  assign state     = state_q;

endmodule
